wash_controller: RTL and testbench
==================================

# wash_controller

Program sequencer for the washing-machine design. Consumes the slow square wave from the clock divider, turns each rising edge of it into a one-`clk` seconds tick, and steps through the fill, wash, rinse, drain and spin phases with per-phase durations. It drives the actuator enables and the door lock, and handles pause, door-open faults and program selection.

## Interface
- `FILL_S`, 8: fill duration in ticks (≥1)
- `WASH_Q_S`, 20: wash duration in ticks for program 0 (quick)
- `WASH_N_S`, 40: wash duration in ticks for program 1 (normal)
- `WASH_I_S`, 60: wash duration in ticks for program 2 (intense)
- `RINSE_S`, 15: rinse duration in ticks
- `DRAIN_S`, 6: drain duration in ticks
- `SPIN_S`, 12: spin duration in ticks
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset
- `slow_clk` in 1: divider output, asynchronous to the FSM logic; rising edge = 1 tick
- `start` in 1: start request; also clears ERROR
- `pause` in 1: level; freezes the active phase
- `door_closed` in 1: door sensor, 1 = closed
- `prog` in 2: 0 quick, 1 normal, 2 intense, 3 spin-only
- `phase` out 3: current state encoding
- `remaining` out 8: ticks left in the current phase
- `water_valve`, `motor_on`, `motor_fast`, `drain_pump`, `door_lock` out 1: actuator enables
- `done` out 1: cycle complete
- `err` out 1: door fault

## Operation
- State encoding: IDLE 0, FILL 1, WASH 2, RINSE 3, DRAIN 4, SPIN 5, DONE 6, ERROR 7.
- Tick generation: 2-flop synchronizer on `slow_clk`, plus rising-edge detect. Produces a one-cycle `tick`.
- IDLE: when `start`=1 and `door_closed`=1, latch `prog`.
  - prog 0–2: go to FILL.
  - prog 3: go to DRAIN.
  - `start` with the door open is ignored.
- Normal sequence: FILL → WASH → RINSE → DRAIN → SPIN → DONE.
- WASH duration is selected by the latched program.
- Phase timer:
  - On entry to a phase, load `remaining` with that phase's duration.
  - On each `tick` while not paused, decrement.
  - A `tick` with `remaining`=1 advances to the next phase and loads the next duration on the same edge. Each phase therefore lasts exactly its duration in ticks.
- Actuators (active phases FILL..SPIN, not paused):
  - FILL: valve.
  - WASH: motor.
  - RINSE: valve + motor.
  - DRAIN: pump.
  - SPIN: motor + fast + pump.
- `door_lock`=1 in FILL..SPIN, including while paused.
- Pause: while `pause`=1 in FILL..SPIN:
  - Ticks are ignored and `remaining` holds.
  - valve, motor, fast and pump are forced 0.
  - Release resumes the same phase with the held count.
  - `pause` has no effect in IDLE, DONE and ERROR.
- Door fault: `door_closed`=0 in FILL..SPIN → ERROR.
  - All actuators off, `door_lock`=0, `err`=1, `remaining`=0.
  - `start`=1 with `door_closed`=1 → IDLE.
- DONE: `done`=1, `door_lock`=0, actuators off, `remaining`=0. `door_closed`=0 → IDLE.
- `start` in any state other than IDLE and ERROR is ignored.
- Priority within one cycle: door fault > pause > tick.
  - Example: door opening on the final tick gives ERROR, not the next phase.

## Timing
- Reset values: `phase`=0, `remaining`=0, all actuator outputs 0, `done`=0, `err`=0, synchronizer and edge flops 0.
- All outputs are registered and change on the same `clk` edge as `phase`.
- Start latency: `start` sampled high at edge N → `phase`=FILL, `water_valve`=1, `remaining`=`FILL_S`, all valid after edge N.
- Tick latency: `slow_clk` rising → `tick` high for one cycle, 2–3 `clk` cycles later.
  - If `slow_clk` is high at reset release, one tick occurs; it is harmless because the FSM is in IDLE.
- Reset asserted mid-cycle: immediate return to IDLE with all actuators off.
- `remaining` never wraps. Durations of 0 are illegal.

## Structure
- Package `wash_pkg`: state-encoding constants (3-bit) and program codes (2-bit).
- Sub-module `tick_sync`: synchronizer plus rising-edge detector. Ports `clk`, `rst`, `slow_clk` in; `tick` out.
- The top level contains the FSM, the phase timer and the registered output decode.

## Test plan
All scenarios use FILL_S=2, WASH_Q_S=3, WASH_N_S=4, WASH_I_S=5, RINSE_S=2, DRAIN_S=2, SPIN_S=2, and `slow_clk` period 20 `clk`.
- Quick cycle: prog=0, `start` with door closed.
  - Phase goes 1,2,3,4,5,6 with tick counts 2,3,2,2,2.
  - Actuator pattern per phase is exact.
  - `done`=1 at the end; opening the door → phase 0.
- Spin-only: prog=3.
  - Phase goes 0→4→5→6.
  - `water_valve` never asserts.
- Pause in WASH at `remaining`=2:
  - Hold across 3 ticks: `remaining` stays 2 and `motor_on`=0 while `door_lock`=1.
  - After release, 2 more ticks → RINSE.
- Door opens in SPIN together with the final tick:
  - phase=7, `err`=1, all actuators 0.
  - `start` with the door still open: stays 7.
  - Door closed + `start` → 0.
- `start` in IDLE with `door_closed`=0: stays 0, no actuator asserts. A `start` pulse in WASH: no effect.
- Async reset asserted mid-RINSE: all outputs 0 immediately. After release, phase=0 and the next `start` runs a full cycle.

Source files
------------

// File: rtl/wash_pkg.sv
// ============================================================================
//  Module      : wash_pkg
//  Description : Shared state encoding and program codes for the washing
//                machine program sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wash_pkg;

    // Phase encoding as seen on the phase output
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_DRAIN = 3'd4,
        ST_SPIN  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } state_t;

    // Program selection codes
    localparam logic [1:0] PROG_QUICK   = 2'd0;
    localparam logic [1:0] PROG_NORMAL  = 2'd1;
    localparam logic [1:0] PROG_INTENSE = 2'd2;
    localparam logic [1:0] PROG_SPIN    = 2'd3;

    // True for the timed phases in which the door must stay locked
    function automatic logic is_active(input state_t s);
        return (s >= ST_FILL) && (s <= ST_SPIN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_sync.sv
// ============================================================================
//  Module      : tick_sync
//  Description : Brings the slow divider square wave into the clk domain and
//                emits a one-cycle tick per rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic slow_clk,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic sync_prev;

    // Two-flop synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= slow_clk;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign tick = sync2 & ~sync_prev;

endmodule

`default_nettype wire

// File: rtl/wash_controller.sv
// ============================================================================
//  Module      : wash_controller
//  Description : Washing machine program sequencer: phase FSM, phase timer
//                and registered actuator / status decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wash_controller
    import wash_pkg::*;
#(
    parameter int FILL_S   = 8,
    parameter int WASH_Q_S = 20,
    parameter int WASH_N_S = 40,
    parameter int WASH_I_S = 60,
    parameter int RINSE_S  = 15,
    parameter int DRAIN_S  = 6,
    parameter int SPIN_S   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       start,
    input  logic       pause,
    input  logic       door_closed,
    input  logic [1:0] prog,
    output logic [2:0] phase,
    output logic [7:0] remaining,
    output logic       water_valve,
    output logic       motor_on,
    output logic       motor_fast,
    output logic       drain_pump,
    output logic       door_lock,
    output logic       done,
    output logic       err
);

    logic       tick;
    state_t     state;
    state_t     state_nxt;
    logic [7:0] rem_nxt;
    logic [1:0] prog_q;
    logic [1:0] prog_nxt;
    logic       valve_nxt;
    logic       motor_nxt;
    logic       fast_nxt;
    logic       pump_nxt;
    logic       lock_nxt;
    logic       done_nxt;
    logic       err_nxt;
    logic       run;

    tick_sync u_tick_sync (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .tick     (tick)
    );

    // Wash length depends on the program latched at start
    function automatic logic [7:0] wash_dur(input logic [1:0] p);
        case (p)
            PROG_QUICK:  return 8'(WASH_Q_S);
            PROG_NORMAL: return 8'(WASH_N_S);
            default:     return 8'(WASH_I_S);
        endcase
    endfunction

    // Next state, next timer value and the output decode of the next state
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        prog_nxt  = prog_q;

        case (state)
            ST_IDLE: begin
                if (start && door_closed) begin
                    prog_nxt = prog;
                    if (prog == PROG_SPIN) begin
                        state_nxt = ST_DRAIN;
                        rem_nxt   = 8'(DRAIN_S);
                    end else begin
                        state_nxt = ST_FILL;
                        rem_nxt   = 8'(FILL_S);
                    end
                end
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_DRAIN, ST_SPIN: begin
                // Door fault outranks pause, which outranks the tick
                if (!door_closed) begin
                    state_nxt = ST_ERROR;
                    rem_nxt   = 8'd0;
                end else if (!pause && tick) begin
                    if (remaining <= 8'd1) begin
                        case (state)
                            ST_FILL:  begin state_nxt = ST_WASH;  rem_nxt = wash_dur(prog_q); end
                            ST_WASH:  begin state_nxt = ST_RINSE; rem_nxt = 8'(RINSE_S);      end
                            ST_RINSE: begin state_nxt = ST_DRAIN; rem_nxt = 8'(DRAIN_S);      end
                            ST_DRAIN: begin state_nxt = ST_SPIN;  rem_nxt = 8'(SPIN_S);       end
                            default:  begin state_nxt = ST_DONE;  rem_nxt = 8'd0;             end
                        endcase
                    end else begin
                        rem_nxt = remaining - 8'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!door_closed) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (start && door_closed) begin
                    state_nxt = ST_IDLE;
                    rem_nxt   = 8'd0;
                end
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it
        run       = !pause;
        lock_nxt  = is_active(state_nxt);
        valve_nxt = run && ((state_nxt == ST_FILL) || (state_nxt == ST_RINSE));
        motor_nxt = run && ((state_nxt == ST_WASH) || (state_nxt == ST_RINSE) ||
                            (state_nxt == ST_SPIN));
        fast_nxt  = run && (state_nxt == ST_SPIN);
        pump_nxt  = run && ((state_nxt == ST_DRAIN) || (state_nxt == ST_SPIN));
        done_nxt  = (state_nxt == ST_DONE);
        err_nxt   = (state_nxt == ST_ERROR);
    end

    // State, timer and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            remaining   <= 8'd0;
            prog_q      <= PROG_QUICK;
            water_valve <= 1'b0;
            motor_on    <= 1'b0;
            motor_fast  <= 1'b0;
            drain_pump  <= 1'b0;
            door_lock   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            remaining   <= rem_nxt;
            prog_q      <= prog_nxt;
            water_valve <= valve_nxt;
            motor_on    <= motor_nxt;
            motor_fast  <= fast_nxt;
            drain_pump  <= pump_nxt;
            door_lock   <= lock_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
        end
    end

    assign phase = state;

endmodule

`default_nettype wire

// File: tb/tb_wash_controller.sv
// ============================================================================
//  Module      : tb_wash_controller
//  Description : Directed self-checking bench for wash_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wash_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       slow_clk;
    logic       start;
    logic       pause;
    logic       door_closed;
    logic [1:0] prog;
    logic [2:0] phase;
    logic [7:0] remaining;
    logic       water_valve;
    logic       motor_on;
    logic       motor_fast;
    logic       drain_pump;
    logic       door_lock;
    logic       done;
    logic       err;

    int n_total  = 0;
    int n_passed = 0;

    // Per-phase expectations for FILL..SPIN: {valve, motor, fast, pump, lock}
    int         exp_phase[5] = '{1, 2, 3, 4, 5};
    int         exp_dur[5]   = '{2, 3, 2, 2, 2};
    logic [4:0] exp_act[5]   = '{5'b10001, 5'b01001, 5'b11001, 5'b00011, 5'b01111};

    wash_controller #(
        .FILL_S   (2),
        .WASH_Q_S (3),
        .WASH_N_S (4),
        .WASH_I_S (5),
        .RINSE_S  (2),
        .DRAIN_S  (2),
        .SPIN_S   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .slow_clk    (slow_clk),
        .start       (start),
        .pause       (pause),
        .door_closed (door_closed),
        .prog        (prog),
        .phase       (phase),
        .remaining   (remaining),
        .water_valve (water_valve),
        .motor_on    (motor_on),
        .motor_fast  (motor_fast),
        .drain_pump  (drain_pump),
        .door_lock   (door_lock),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    function automatic logic [4:0] act();
        return {water_valve, motor_on, motor_fast, drain_pump, door_lock};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    // One slow_clk period of 20 clk; the tick has been consumed on return
    task automatic do_tick();
        @(negedge clk) slow_clk = 1'b1;
        repeat (10) @(negedge clk);
        slow_clk = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Walk phases from table index 'first' through DONE with exact checks
    task automatic run_from(input int first);
        for (int p = first; p < 5; p++) begin
            check("phase", 32'(phase), 32'(exp_phase[p]));
            check("rem_load", 32'(remaining), 32'(exp_dur[p]));
            check("act", 32'(act()), 32'(exp_act[p]));
            for (int t = 1; t <= exp_dur[p]; t++) begin
                do_tick();
                if (t < exp_dur[p]) begin
                    check("rem_dec", 32'(remaining), 32'(exp_dur[p] - t));
                    check("act_hold", 32'(act()), 32'(exp_act[p]));
                end
            end
        end
        check("done_phase", 32'(phase), 32'd6);
        check("done_flag", 32'(done), 32'd1);
        check("done_act", 32'(act()), 32'd0);
        check("done_rem", 32'(remaining), 32'd0);
    endtask

    task automatic open_close_door();
        @(negedge clk) door_closed = 1'b0;
        @(negedge clk);
        check("door_to_idle", 32'(phase), 32'd0);
        door_closed = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        slow_clk    = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        door_closed = 1'b1;
        prog        = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_rem", 32'(remaining), 32'd0);
        check("rst_out", 32'({act(), done, err}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Start with the door open is ignored
        door_closed = 1'b0;
        pulse_start();
        check("open_start_phase", 32'(phase), 32'd0);
        check("open_start_act", 32'(act()), 32'd0);
        door_closed = 1'b1;
        @(negedge clk);

        // Quick cycle
        prog = 2'd0;
        pulse_start();
        run_from(0);
        open_close_door();

        // Spin-only program skips straight to drain
        prog = 2'd3;
        pulse_start();
        check("spin_valve", 32'(water_valve), 32'd0);
        run_from(3);
        open_close_door();

        // Pause in WASH with remaining = 2, plus an ignored start pulse
        prog = 2'd0;
        pulse_start();
        repeat (2) do_tick();
        check("wash_entry", 32'(phase), 32'd2);
        pulse_start();
        check("wash_start_ign", 32'({phase, remaining}), {21'd0, 3'd2, 8'd3});
        do_tick();
        check("wash_rem2", 32'(remaining), 32'd2);
        @(negedge clk) pause = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check("pause_rem", 32'(remaining), 32'd2);
            check("pause_act", 32'(act()), 32'b00001);
            check("pause_phase", 32'(phase), 32'd2);
        end
        pause = 1'b0;
        @(negedge clk);
        check("resume_motor", 32'(motor_on), 32'd1);
        do_tick();
        check("resume_rem", 32'(remaining), 32'd1);
        do_tick();
        check("to_rinse", 32'(phase), 32'd3);
        check("rinse_act", 32'(act()), 32'b11001);

        // Asynchronous reset mid-RINSE
        repeat (4) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_phase", 32'(phase), 32'd0);
        check("arst_out", 32'({remaining, act(), done, err}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_phase", 32'(phase), 32'd0);
        prog = 2'd0;
        pulse_start();
        run_from(0);
        open_close_door();

        // Door opens in SPIN on the same cycle as the final tick
        prog = 2'd0;
        pulse_start();
        repeat (9) do_tick();
        check("spin_entry", 32'(phase), 32'd5);
        do_tick();
        check("spin_rem1", 32'(remaining), 32'd1);
        @(negedge clk) slow_clk = 1'b1;
        @(negedge clk);
        @(negedge clk) door_closed = 1'b0;
        repeat (8) @(negedge clk);
        slow_clk = 1'b0;
        repeat (10) @(negedge clk);
        check("fault_phase", 32'(phase), 32'd7);
        check("fault_err", 32'(err), 32'd1);
        check("fault_out", 32'({remaining, act(), done}), 32'd0);
        pulse_start();
        check("fault_stay", 32'(phase), 32'd7);
        door_closed = 1'b1;
        pulse_start();
        check("fault_clear", 32'(phase), 32'd0);
        check("fault_clear_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

`default_nettype wire
